// File: rtl/stopwatch_bcd_counter.sv
// MM:SS BCD stopwatch counter (00:00..99:59) with lap-freeze display and sticky overflow.
// Counts rising edges of the upstream-gated 1 Hz pulse; outputs feed the 7-segment mux.
`timescale 1ns/1ps
module stopwatch_bcd_counter #(
    parameter int SATURATE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse_1HZ,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       frozen,
    output logic       overflow
);

    typedef enum logic {LIVE = 1'b0, FROZEN = 1'b1} state_t;

    state_t     r_state;
    logic       r_pulse_d;
    logic       r_lap_d;
    logic       r_overflow;
    logic [3:0] r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
    logic [3:0] r_snap_sec_ones, r_snap_sec_tens, r_snap_min_ones, r_snap_min_tens;

    logic w_inc;
    logic w_lap_edge;
    logic w_terminal;

    assign w_inc      = pulse_1HZ & ~r_pulse_d;
    assign w_lap_edge = lap & ~r_lap_d;
    assign w_terminal = (r_min_tens == 4'd9) && (r_min_ones == 4'd9) &&
                        (r_sec_tens == 4'd5) && (r_sec_ones == 4'd9);

    // Edge registers sample every cycle, even during clear, so a held level never re-counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pulse_d <= 1'b0;
            r_lap_d   <= 1'b0;
        end else begin
            r_pulse_d <= pulse_1HZ;
            r_lap_d   <= lap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
            r_overflow <= 1'b0;
        end else if (w_inc) begin
            if (w_terminal) begin
                r_overflow <= 1'b1;
                if (SATURATE == 0) begin
                    r_sec_ones <= 4'd0;
                    r_sec_tens <= 4'd0;
                    r_min_ones <= 4'd0;
                    r_min_tens <= 4'd0;
                end
            end else if (r_sec_ones != 4'd9) begin
                r_sec_ones <= r_sec_ones + 4'd1;
            end else begin
                r_sec_ones <= 4'd0;
                if (r_sec_tens != 4'd5) begin
                    r_sec_tens <= r_sec_tens + 4'd1;
                end else begin
                    r_sec_tens <= 4'd0;
                    if (r_min_ones != 4'd9) begin
                        r_min_ones <= r_min_ones + 4'd1;
                    end else begin
                        r_min_ones <= 4'd0;
                        r_min_tens <= r_min_tens + 4'd1;
                    end
                end
            end
        end
    end

    // Snapshot takes the pre-increment count when a lap edge and an increment coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= LIVE;
            r_snap_sec_ones <= 4'd0;
            r_snap_sec_tens <= 4'd0;
            r_snap_min_ones <= 4'd0;
            r_snap_min_tens <= 4'd0;
        end else if (clear) begin
            r_state         <= LIVE;
            r_snap_sec_ones <= 4'd0;
            r_snap_sec_tens <= 4'd0;
            r_snap_min_ones <= 4'd0;
            r_snap_min_tens <= 4'd0;
        end else if (w_lap_edge) begin
            case (r_state)
                LIVE: begin
                    r_state         <= FROZEN;
                    r_snap_sec_ones <= r_sec_ones;
                    r_snap_sec_tens <= r_sec_tens;
                    r_snap_min_ones <= r_min_ones;
                    r_snap_min_tens <= r_min_tens;
                end
                default: r_state <= LIVE;
            endcase
        end
    end

    assign frozen   = (r_state == FROZEN);
    assign overflow = r_overflow;
    assign sec_ones = frozen ? r_snap_sec_ones : r_sec_ones;
    assign sec_tens = frozen ? r_snap_sec_tens : r_sec_tens;
    assign min_ones = frozen ? r_snap_min_ones : r_min_ones;
    assign min_tens = frozen ? r_snap_min_tens : r_min_tens;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter: one wrap-around instance and one saturating
// instance share the same stimulus; displays are compared as packed BCD MMSS words.
`timescale 1ns/1ps
module tb_stopwatch_bcd_counter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pulse_1HZ = 1'b0;
    logic clear = 1'b0;
    logic lap = 1'b0;

    logic [3:0] so0, st0, mo0, mt0, so1, st1, mo1, mt1;
    logic       frz0, ovf0, frz1, ovf1;
    logic [15:0] disp0, disp1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stopwatch_bcd_counter #(.SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .pulse_1HZ(pulse_1HZ), .clear(clear), .lap(lap),
        .sec_ones(so0), .sec_tens(st0), .min_ones(mo0), .min_tens(mt0),
        .frozen(frz0), .overflow(ovf0)
    );

    stopwatch_bcd_counter #(.SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .pulse_1HZ(pulse_1HZ), .clear(clear), .lap(lap),
        .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1),
        .frozen(frz1), .overflow(ovf1)
    );

    assign disp0 = {mt0, mo0, st0, so0};
    assign disp1 = {mt1, mo1, st1, so1};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_once();
        pulse_1HZ = 1'b1;
        tick();
        pulse_1HZ = 1'b0;
        tick();
    endtask

    task automatic lap_once();
        lap = 1'b1;
        tick();
        lap = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_disp0", disp0, 16'h0000);
        check("rst_disp1", disp1, 16'h0000);
        check("rst_frz_ovf", {14'd0, frz0, ovf0}, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // 60 single-cycle pulses 1000 clocks apart
        for (int i = 0; i < 60; i++) begin
            pulse_1HZ = 1'b1;
            tick();
            pulse_1HZ = 1'b0;
            repeat (999) tick();
        end
        check("sixty_disp", disp0, 16'h0100);
        check("sixty_frz_ovf", {14'd0, frz0, ovf0}, 16'h0000);

        // Long pulse counts once, with one cycle of latency
        do_clear();
        check("clr_disp", disp0, 16'h0000);
        pulse_1HZ = 1'b1;
        check("long_before_edge", disp0, 16'h0000);
        tick();
        check("long_first_cycle", disp0, 16'h0001);
        repeat (49) tick();
        pulse_1HZ = 1'b0;
        tick();
        check("long_after", disp0, 16'h0001);

        // Preload to 99:58, then cross the terminal value
        do_clear();
        for (int i = 0; i < 5998; i++) pulse_once();
        check("pre_9958_wrap", disp0, 16'h9958);
        check("pre_9958_sat", disp1, 16'h9958);
        pulse_once();
        check("at_9959_wrap", disp0, 16'h9959);
        check("at_9959_sat", disp1, 16'h9959);
        check("at_9959_ovf", {14'd0, ovf0, ovf1}, 16'h0000);
        pulse_once();
        check("wrap_disp", disp0, 16'h0000);
        check("sat_disp", disp1, 16'h9959);
        check("term_ovf", {14'd0, ovf0, ovf1}, 16'h0003);
        pulse_once();
        check("wrap_next", disp0, 16'h0001);
        check("sat_hold", disp1, 16'h9959);
        check("ovf_sticky", {14'd0, ovf0, ovf1}, 16'h0003);
        do_clear();
        check("clr_wrap", disp0, 16'h0000);
        check("clr_sat", disp1, 16'h0000);
        check("clr_ovf", {14'd0, ovf0, ovf1}, 16'h0000);

        // Lap edge coincident with increment at 00:12
        for (int i = 0; i < 12; i++) pulse_once();
        check("at_0012", disp0, 16'h0012);
        pulse_1HZ = 1'b1;
        lap = 1'b1;
        tick();
        check("lap_frz", {15'd0, frz0}, 16'h0001);
        check("lap_snap", disp0, 16'h0012);
        pulse_1HZ = 1'b0;
        lap = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            pulse_once();
            check("frozen_hold", disp0, 16'h0012);
        end
        lap = 1'b1;
        tick();
        check("unlap_frz", {15'd0, frz0}, 16'h0000);
        check("unlap_live", disp0, 16'h0018);
        lap = 1'b0;
        tick();

        // Clear beats a simultaneous pulse edge and lap edge while frozen at 00:30
        for (int i = 0; i < 12; i++) pulse_once();
        lap_once();
        check("f30_frz", {15'd0, frz0}, 16'h0001);
        check("f30_disp", disp0, 16'h0030);
        clear = 1'b1;
        pulse_1HZ = 1'b1;
        lap = 1'b1;
        tick();
        check("clr_prio_disp", disp0, 16'h0000);
        check("clr_prio_frz", {15'd0, frz0}, 16'h0000);
        clear = 1'b0;
        tick();
        check("held_no_recount", disp0, 16'h0000);
        check("held_no_relap", {15'd0, frz0}, 16'h0000);
        pulse_1HZ = 1'b0;
        lap = 1'b0;
        tick();

        // Asynchronous reset while frozen at 07:45
        for (int i = 0; i < 465; i++) pulse_once();
        lap_once();
        check("f745_disp", disp0, 16'h0745);
        check("f745_frz", {15'd0, frz0}, 16'h0001);
        #2 rst = 1'b0;
        #1;
        check("arst_disp", disp0, 16'h0000);
        check("arst_frz_ovf", {14'd0, frz0, ovf0}, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        check("post_rst_disp", disp0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
